// File: rtl/main_fsm.sv
// Multicycle RV32I main controller: Moore FSM sequencing fetch/decode/execute/memory/writeback.
// Define MAIN_FSM_BNE_EN to let the branch state honour funct3 (beq/bne); otherwise every branch is beq.
module main_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic [1:0] imm_src
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_ALUWB    = 4'd7;
    localparam logic [3:0] S_EXECUTEI = 4'd8;
    localparam logic [3:0] S_JAL      = 4'd9;
    localparam logic [3:0] S_BEQ      = 4'd10;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [3:0] state_q;
    logic [3:0] state_d;

    logic       pc_update;
    logic       branch;
    logic       take;
    logic       ir_write_s;
    logic       mem_write_s;
    logic       reg_write_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECUTER;
                    OP_ITYPE:          state_d = S_EXECUTEI;
                    OP_JAL:            state_d = S_JAL;
                    OP_BRANCH:         state_d = S_BEQ;
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = S_FETCH;
            S_EXECUTER: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_EXECUTEI: state_d = S_ALUWB;
            S_JAL:      state_d = S_ALUWB;
            S_BEQ:      state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pc_update   = 1'b0;
        branch      = 1'b0;
        ir_write_s  = 1'b0;
        mem_write_s = 1'b0;
        reg_write_s = 1'b0;
        adr_src     = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_op      = 2'b00;
        case (state_q)
            S_FETCH: begin
                ir_write_s = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                pc_update  = 1'b1;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src  = 2'b01;
                reg_write_s = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src     = 1'b1;
                mem_write_s = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_write_s = 1'b1;
            end
            S_EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
            end
            default: begin
            end
        endcase
    end

`ifdef MAIN_FSM_BNE_EN
    always_comb begin
        case (funct3)
            3'b000:  take = zero;
            3'b001:  take = ~zero;
            default: take = 1'b0;
        endcase
    end
`else
    logic unused_funct3;
    assign unused_funct3 = ^funct3;
    assign take = zero;
`endif

    // The state already sits in FETCH during reset, so only the enables need masking.
    assign pc_write  = ~reset & (pc_update | (branch & take));
    assign ir_write  = ~reset & ir_write_s;
    assign mem_write = ~reset & mem_write_s;
    assign reg_write = ~reset & reg_write_s;

    always_comb begin
        case (op)
            OP_LOAD, OP_ITYPE: imm_src = 2'b00;
            OP_STORE:          imm_src = 2'b01;
            OP_BRANCH:         imm_src = 2'b10;
            OP_JAL:            imm_src = 2'b11;
            default:           imm_src = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_main_fsm.sv
// Randomized check of main_fsm against a step-list reference model built from the instruction class.
`timescale 1ns/1ps
module tb_main_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       zero;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;

    int n_checks = 0;
    int n_fail   = 0;

    main_fsm dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .zero(zero),
        .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .reg_write(reg_write), .imm_src(imm_src)
    );

    always #5 clk = ~clk;

    // Control word: {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b, alu_op, reg_write, imm_src}
    function automatic logic [14:0] observed();
        return {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                alu_src_b, alu_op, reg_write, imm_src};
    endfunction

    task automatic check_eq(input string tag, input logic [14:0] got, input logic [14:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (op=%b f3=%b zero=%b)", tag, got, exp, op, funct3, zero);
        end else begin
            $display("ok   %s: %b (op=%b f3=%b zero=%b)", tag, got, op, funct3, zero);
        end
    endtask

    function automatic logic [1:0] imm_of(input logic [6:0] o);
        if (o == 7'b0000011 || o == 7'b0010011) return 2'b00;
        if (o == 7'b0100011) return 2'b01;
        if (o == 7'b1100011) return 2'b10;
        if (o == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3, input logic z);
`ifdef MAIN_FSM_BNE_EN
        if (f3 == 3'b000) return z;
        if (f3 == 3'b001) return ~z;
        return 1'b0;
`else
        return z;
`endif
    endfunction

    // Expected control word for a named step of the instruction walk.
    function automatic logic [14:0] expect_word(input string st, input logic [6:0] o,
                                                input logic [2:0] f3, input logic z);
        logic pcw, adr, mw, irw, rw;
        logic [1:0] rs, sa, sb, ao;
        pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; rs = 0; sa = 0; sb = 0; ao = 0;
        if (st == "FETCH") begin
            pcw = 1; irw = 1; sb = 2'b10; rs = 2'b10;
        end else if (st == "RESET") begin
            sb = 2'b10; rs = 2'b10;
        end else if (st == "DECODE") begin
            sa = 2'b01; sb = 2'b01;
        end else if (st == "MEMADR") begin
            sa = 2'b10; sb = 2'b01;
        end else if (st == "MEMREAD") begin
            adr = 1;
        end else if (st == "MEMWB") begin
            rs = 2'b01; rw = 1;
        end else if (st == "MEMWRITE") begin
            adr = 1; mw = 1;
        end else if (st == "EXECUTER") begin
            sa = 2'b10; ao = 2'b10;
        end else if (st == "ALUWB") begin
            rw = 1;
        end else if (st == "EXECUTEI") begin
            sa = 2'b10; sb = 2'b01; ao = 2'b10;
        end else if (st == "JAL") begin
            sa = 2'b01; sb = 2'b10; pcw = 1;
        end else if (st == "BEQ") begin
            sa = 2'b10; ao = 2'b01; pcw = branch_taken(f3, z);
        end
        return {pcw, adr, mw, irw, rs, sa, sb, ao, rw, imm_of(o)};
    endfunction

    function automatic void build_steps(input logic [6:0] o, output string q[$]);
        q = {"FETCH", "DECODE"};
        case (o)
            7'b0000011: q = {q, "MEMADR", "MEMREAD", "MEMWB"};
            7'b0100011: q = {q, "MEMADR", "MEMWRITE"};
            7'b0110011: q = {q, "EXECUTER", "ALUWB"};
            7'b0010011: q = {q, "EXECUTEI", "ALUWB"};
            7'b1101111: q = {q, "JAL", "ALUWB"};
            7'b1100011: q = {q, "BEQ"};
            default: ;
        endcase
    endfunction

    // Entered 2ns after a rising edge with the DUT in FETCH; leaves the same way.
    // zsel: 0/1 force zero, 2 randomizes it each cycle. abort_at >= 0 pulses reset in that step.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input int zsel, input int abort_at);
        string steps[$];
        build_steps(o, steps);
        op = o;
        funct3 = f3;
        for (int i = 0; i < steps.size(); i++) begin
            zero = (zsel == 2) ? 1'($urandom_range(0, 1)) : 1'(zsel);
            #1;
            check_eq(steps[i], observed(), expect_word(steps[i], o, f3, zero));
            if (i == abort_at) begin
                #1 reset = 1'b1;
                #1 check_eq("reset_abort", observed(), expect_word("RESET", o, f3, zero));
                @(posedge clk);
                #2 check_eq("reset_hold", observed(), expect_word("RESET", o, f3, zero));
                reset = 1'b0;
                return;
            end
            @(posedge clk);
            #2;
        end
    endtask

    function automatic logic [6:0] rand_op();
        logic [6:0] tbl [7];
        int k;
        tbl = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100011, 7'b0000000};
        k = $urandom_range(0, 7);
        if (k == 7) return 7'($urandom);
        return tbl[k];
    endfunction

    initial begin
        reset  = 1'b1;
        op     = 7'b0000011;
        funct3 = 3'b000;
        zero   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #3 check_eq("reset_held", observed(), expect_word("RESET", op, funct3, zero));
        end
        @(posedge clk);
        #2 reset = 1'b0;

        run_instr(7'b0000011, 3'b000, 2, -1);          // lw
        run_instr(7'b0110011, 3'b000, 2, -1);          // R-type
        run_instr(7'b1100011, 3'b000, 1, -1);          // beq taken
        run_instr(7'b1100011, 3'b000, 0, -1);          // beq not taken
        run_instr(7'b1100011, 3'b001, 0, -1);          // bne, zero=0
        run_instr(7'b1100011, 3'b001, 1, -1);          // bne, zero=1
        run_instr(7'b1100011, 3'b100, 1, -1);          // other funct3
        run_instr(7'b0000000, 3'b000, 2, -1);          // illegal opcode
        run_instr(7'b0100011, 3'b010, 2, -1);          // sw
        run_instr(7'b0010011, 3'b000, 2, -1);          // I-type
        run_instr(7'b1101111, 3'b000, 2, -1);          // jal
        run_instr(7'b0100011, 3'b010, 2, 3);           // reset during MEMWRITE
        run_instr(7'b0110011, 3'b000, 2, 1);           // reset during DECODE

        for (int n = 0; n < 300; n++) begin
            logic [6:0] o;
            o = rand_op();
            run_instr(o, 3'($urandom), 2, ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 4)) : -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
